// File: rtl/dbg_apb_master.sv
// dbg_apb_master: bridges one decoded JTAG debug access onto the APB bus stage.
// The address picks a one-hot slave select (index = addr >> SLAVE_SHIFT). Only one
// transfer is outstanding at a time. The response carries read data and an error
// flag, and is held until the consumer takes it.
// Optional build macro DBG_APB_TIMEOUT_EN: aborts a transfer that stays in XFER
// for TIMEOUT_CYCLES cycles and reports it as an error. Without the macro a
// transfer waits for the slave indefinitely.
module dbg_apb_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int WDATA_WIDTH    = 32,
   parameter int RDATA_WIDTH    = 32,
   parameter int NR_SLAVES      = 4,
   parameter int SLAVE_SHIFT    = 12,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_wr,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [WDATA_WIDTH-1:0] req_wdata,
   input  logic [3:0]             req_wstrobe,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [RDATA_WIDTH-1:0] rsp_rdata,
   output logic                   rsp_err,
   output logic [ADDR_WIDTH-1:0]  apb_addr,
   output logic [NR_SLAVES-1:0]   apb_sel,
   output logic                   apb_wr_rd,
   output logic [WDATA_WIDTH-1:0] apb_wdata,
   output logic [3:0]             apb_wstrobe,
   input  logic                   apb_enable,
   input  logic                   apb_ready,
   input  logic [RDATA_WIDTH-1:0] apb_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   idx;
   logic [NR_SLAVES-1:0]    sel_dec;
   logic                    decode_ok;
   logic                    xfer_done;

`ifdef DBG_APB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
   logic [CNT_W-1:0]        tmo_cnt;
`endif

   // Acceptance only in IDLE with the bus drained, and never while reset is held.
   assign req_ready = rst_n && (state == IDLE) && !apb_enable;

   // A slave only counts as finished in its ACCESS phase.
   assign xfer_done = apb_enable && apb_ready;

   // Address decode into a one-hot select; an all-zero result is a decode error.
   always_comb begin
      idx     = req_addr >> SLAVE_SHIFT;
      sel_dec = '0;
      for (int i = 0; i < NR_SLAVES; i++) begin
         if (idx == ADDR_WIDTH'(i)) sel_dec[i] = 1'b1;
      end
      decode_ok = |sel_dec;
   end

   // Transfer FSM with all bus and response outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_rdata   <= '0;
         apb_sel     <= '0;
         apb_addr    <= '0;
         apb_wdata   <= '0;
         apb_wstrobe <= '0;
         apb_wr_rd   <= 1'b0;
`ifdef DBG_APB_TIMEOUT_EN
         tmo_cnt     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  apb_addr    <= req_addr;
                  apb_wdata   <= req_wdata;
                  apb_wstrobe <= req_wstrobe;
                  apb_wr_rd   <= req_wr;
                  if (decode_ok) begin
                     apb_sel <= sel_dec;
                     state   <= XFER;
`ifdef DBG_APB_TIMEOUT_EN
                     tmo_cnt <= '0;
`endif
                  end else begin
                     // Unmapped slave: answer immediately without touching the bus.
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end
               end
            end
            XFER: begin
               if (xfer_done) begin
                  rsp_rdata <= apb_wr_rd ? '0 : apb_rdata;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  apb_sel   <= '0;
                  state     <= RESP;
               end
`ifdef DBG_APB_TIMEOUT_EN
               // Completion takes priority over an abort in the same cycle.
               else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  apb_sel   <= '0;
                  state     <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_apb_master.sv
// Directed bench for dbg_apb_master. The APB bus stage is driven cycle by cycle:
// the bus shows one setup cycle after sel appears, then raises apb_enable.
// Define DBG_APB_TIMEOUT_EN for both files to exercise the timeout build.
module tb_dbg_apb_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrobe;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] apb_addr;
   logic [3:0]  apb_sel;
   logic        apb_wr_rd;
   logic [31:0] apb_wdata;
   logic [3:0]  apb_wstrobe;
   logic        apb_enable;
   logic        apb_ready;
   logic [31:0] apb_rdata;

   int n_checks = 0;
   int n_errors = 0;

   dbg_apb_master #(
      .ADDR_WIDTH    (32),
      .WDATA_WIDTH   (32),
      .RDATA_WIDTH   (32),
      .NR_SLAVES     (4),
      .SLAVE_SHIFT   (12),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrobe(req_wstrobe),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .apb_addr   (apb_addr),
      .apb_sel    (apb_sel),
      .apb_wr_rd  (apb_wr_rd),
      .apb_wdata  (apb_wdata),
      .apb_wstrobe(apb_wstrobe),
      .apb_enable (apb_enable),
      .apb_ready  (apb_ready),
      .apb_rdata  (apb_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one cycle; returns in the first cycle after acceptance.
   task automatic start_req(input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
      req_valid   = 1'b1;
      req_wr      = wr;
      req_addr    = addr;
      req_wdata   = data;
      req_wstrobe = strb;
      #1;
      check("req_ready_before_accept", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
   endtask

   int bad;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
      req_wdata = '0; req_wstrobe = '0; rsp_ready = 1'b0;
      apb_enable = 1'b0; apb_ready = 1'b0; apb_rdata = '0;
      tick(); tick();

      // Reset values
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_sel", apb_sel, 4'b0000);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_apb_addr", apb_addr, 32'h0);
      check("rst_apb_wdata", apb_wdata, 32'h0);
      check("rst_apb_wstrobe", apb_wstrobe, 4'h0);
      check("rst_apb_wr_rd", apb_wr_rd, 1'b0);
      rst_n = 1'b1;
      tick();
      check("post_rst_req_ready", req_ready, 1'b1);

      // Test 1: zero-wait write to slave 1, response in cycle 4 after accept
      start_req(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
      check("t1_sel", apb_sel, 4'b0010);
      check("t1_wr_rd", apb_wr_rd, 1'b1);
      check("t1_addr", apb_addr, 32'h0000_1004);
      check("t1_wdata", apb_wdata, 32'hDEAD_BEEF);
      check("t1_wstrobe", apb_wstrobe, 4'hF);
      check("t1_req_ready_busy", req_ready, 1'b0);
      tick();                                   // cycle 2: bus setup
      check("t1_rsp_valid_c2", rsp_valid, 1'b0);
      tick();                                   // cycle 3: access, slave ready
      apb_enable = 1'b1; apb_ready = 1'b1;
      check("t1_sel_c3", apb_sel, 4'b0010);
      check("t1_rsp_valid_c3", rsp_valid, 1'b0);
      tick();                                   // cycle 4
      apb_enable = 1'b0; apb_ready = 1'b0;
      check("t1_rsp_valid_c4", rsp_valid, 1'b1);
      check("t1_rsp_err", rsp_err, 1'b0);
      check("t1_rsp_rdata", rsp_rdata, 32'h0);
      check("t1_sel_dropped", apb_sel, 4'b0000);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t1_rsp_consumed", rsp_valid, 1'b0);
      check("t1_idle_ready", req_ready, 1'b1);

      // Test 2: read from slave 3 with 5 wait cycles; stray apb_ready without enable
      start_req(1'b0, 32'h0000_3000, 32'h0, 4'h0);
      check("t2_sel", apb_sel, 4'b1000);
      check("t2_wr_rd", apb_wr_rd, 1'b0);
      apb_ready = 1'b1; apb_rdata = 32'hBAD0_BAD0;
      tick();
      check("t2_ready_wo_enable_ignored", rsp_valid, 1'b0);
      check("t2_sel_setup", apb_sel, 4'b1000);
      apb_ready = 1'b0; apb_enable = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (apb_sel !== 4'b1000 || rsp_valid !== 1'b0) bad++;
      end
      check("t2_sel_held_waits", bad, 0);
      apb_ready = 1'b1; apb_rdata = 32'h1234_5678;
      tick();
      apb_enable = 1'b0; apb_ready = 1'b0; apb_rdata = 32'h0;
      check("t2_rsp_valid", rsp_valid, 1'b1);
      check("t2_rsp_rdata", rsp_rdata, 32'h1234_5678);
      check("t2_rsp_err", rsp_err, 1'b0);
      check("t2_sel_dropped", apb_sel, 4'b0000);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t2_rsp_consumed", rsp_valid, 1'b0);

      // Test 3: decode error, idx 5 beyond 4 slaves
      start_req(1'b0, 32'h0000_5000, 32'h0, 4'h0);
      check("t3_sel_none", apb_sel, 4'b0000);
      check("t3_rsp_valid", rsp_valid, 1'b1);
      check("t3_rsp_err", rsp_err, 1'b1);
      check("t3_rsp_rdata", rsp_rdata, 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t3_rsp_consumed", rsp_valid, 1'b0);

      // Test 5: response back-pressure, bus draining, then back-to-back request
      start_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
      check("t5_sel0", apb_sel, 4'b0001);
      tick();
      apb_enable = 1'b1; apb_ready = 1'b1; apb_rdata = 32'hA5A5_5A5A;
      tick();
      apb_enable = 1'b0; apb_ready = 1'b0; apb_rdata = 32'h0;
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0000_2008;
      req_wdata = 32'h0BAD_F00D; req_wstrobe = 4'h3;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_5A5A
             || rsp_err !== 1'b0 || apb_sel !== 4'b0000) bad++;
         tick();
      end
      check("t5_rsp_held_stable", bad, 0);
      rsp_ready = 1'b1; apb_enable = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t5_rsp_released", rsp_valid, 1'b0);
      check("t5_draining_blocks", req_ready, 1'b0);
      tick();
      check("t5_no_sel_while_draining", apb_sel, 4'b0000);
      check("t5_still_blocked", req_ready, 1'b0);
      apb_enable = 1'b0;
      #1;
      check("t5_ready_after_drain", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      check("t5_second_sel", apb_sel, 4'b0100);
      check("t5_second_addr", apb_addr, 32'h0000_2008);
      check("t5_second_wdata", apb_wdata, 32'h0BAD_F00D);
      check("t5_second_wstrobe", apb_wstrobe, 4'h3);
      tick();
      apb_enable = 1'b1; apb_ready = 1'b1; apb_rdata = 32'hFFFF_FFFF;
      tick();
      apb_enable = 1'b0; apb_ready = 1'b0; apb_rdata = 32'h0;
      check("t5_second_rsp_valid", rsp_valid, 1'b1);
      check("t5_write_rdata_zero", rsp_rdata, 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Test 4: slave never ready
`ifdef DBG_APB_TIMEOUT_EN
      start_req(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      apb_enable = 1'b1; apb_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (apb_sel !== 4'b0010 || rsp_valid !== 1'b0) bad++;
         tick();
      end
      apb_enable = 1'b0;
      check("t4_sel_held_16", bad, 0);
      check("t4_sel_dropped", apb_sel, 4'b0000);
      check("t4_rsp_valid", rsp_valid, 1'b1);
      check("t4_rsp_err", rsp_err, 1'b1);
      check("t4_rsp_rdata", rsp_rdata, 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Completion on the limit cycle wins over the timeout
      start_req(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      apb_enable = 1'b1; apb_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check("t4b_still_xfer", apb_sel, 4'b0010);
      apb_ready = 1'b1; apb_rdata = 32'hCAFE_0001;
      tick();
      apb_enable = 1'b0; apb_ready = 1'b0; apb_rdata = 32'h0;
      check("t4b_rsp_valid", rsp_valid, 1'b1);
      check("t4b_rsp_err_clear", rsp_err, 1'b0);
      check("t4b_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Test 6 setup: a read left mid-XFER
      start_req(1'b0, 32'h0000_2000, 32'h0, 4'h0);
      apb_enable = 1'b1;
      tick(); tick();
      check("t6_pre_sel", apb_sel, 4'b0100);
`else
      start_req(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      apb_enable = 1'b1; apb_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (apb_sel !== 4'b0010 || rsp_valid !== 1'b0) bad++;
      end
      check("t4_waits_forever", bad, 0);
      check("t4_sel_held", apb_sel, 4'b0010);
      check("t4_no_rsp", rsp_valid, 1'b0);
`endif

      // Test 6: reset mid-XFER drops the transfer
      rst_n = 1'b0; apb_enable = 1'b0;
      tick();
      check("t6_sel_cleared", apb_sel, 4'b0000);
      check("t6_rsp_valid", rsp_valid, 1'b0);
      check("t6_req_ready_in_rst", req_ready, 1'b0);
      check("t6_addr_cleared", apb_addr, 32'h0);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rsp_valid !== 1'b0 || apb_sel !== 4'b0000) bad++;
      end
      check("t6_no_response", bad, 0);
      check("t6_idle_ready", req_ready, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
